// File: rtl/pc_sequencer_if.sv
// Handshake bundle between the branch/jump resolver, instruction memory and the PC sequencer.
// The slave modport is the sequencer's view; the master modport is the driving side.
interface pc_sequencer_if #(
  parameter int PC_W = 9
);
  logic            ctrl_en;
  logic            jump;
  logic [PC_W-1:0] endout;
  logic            is_jal;
  logic            stall;
  logic            halt;
  logic            imem_ready;
  logic [PC_W-1:0] pc;
  logic            fetch_req;
  logic [PC_W-1:0] link_addr;
  logic            link_we;
  logic            halted;

  modport master (
    output ctrl_en, jump, endout, is_jal, stall, halt, imem_ready,
    input  pc, fetch_req, link_addr, link_we, halted
  );

  modport slave (
    input  ctrl_en, jump, endout, is_jal, stall, halt, imem_ready,
    output pc, fetch_req, link_addr, link_we, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage: FETCH/EXEC sequencing, next-PC selection, jal link capture and halt.
// All outputs come straight from registers.
module pc_sequencer #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  pc_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state_r;
  logic [PC_W-1:0] pc_r;
  logic            fetch_req_r;
  logic [PC_W-1:0] link_addr_r;
  logic            link_we_r;
  logic            halted_r;
  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] next_pc_s;

  // Next-PC select; the resolver returns pc for not-taken, so branch results are bumped by one
  always_comb begin
    pc_inc_s  = pc_r + PC_ONE;
    next_pc_s = pc_inc_s;
    if (bus.ctrl_en) begin
      if (bus.jump) begin
        next_pc_s = bus.endout;
      end else begin
        next_pc_s = bus.endout + PC_ONE;
      end
    end else begin
      next_pc_s = pc_inc_s;
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_FETCH;
      pc_r        <= RESET_PC;
      fetch_req_r <= 1'b1;
      link_addr_r <= {PC_W{1'b0}};
      link_we_r   <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      link_we_r <= 1'b0;
      case (state_r)
        ST_FETCH: begin
          if (bus.imem_ready) begin
            state_r     <= ST_EXEC;
            fetch_req_r <= 1'b0;
          end else begin
            state_r     <= ST_FETCH;
            fetch_req_r <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (bus.stall) begin
            state_r     <= ST_EXEC;
            fetch_req_r <= 1'b0;
          end else if (bus.halt) begin
            state_r     <= ST_HALT;
            fetch_req_r <= 1'b0;
            halted_r    <= 1'b1;
          end else begin
            state_r     <= ST_FETCH;
            fetch_req_r <= 1'b1;
            pc_r        <= next_pc_s;
            if (bus.ctrl_en && bus.is_jal) begin
              link_addr_r <= pc_inc_s;
              link_we_r   <= 1'b1;
            end else begin
              link_addr_r <= link_addr_r;
            end
          end
        end
        ST_HALT: begin
          state_r     <= ST_HALT;
          fetch_req_r <= 1'b0;
          halted_r    <= 1'b1;
        end
        default: begin
          // Unreachable encoding: recover by restarting the fetch at the current PC
          state_r     <= ST_FETCH;
          fetch_req_r <= 1'b1;
          halted_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc        = pc_r;
  assign bus.fetch_req = fetch_req_r;
  assign bus.link_addr = link_addr_r;
  assign bus.link_we   = link_we_r;
  assign bus.halted    = halted_r;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed spot checks plus randomized traffic
// compared every cycle against a behavioural model of the fetch/execute rules.
module tb_pc_sequencer;
  localparam int PC_W = 9;
  localparam int MOD  = 512;

  logic clock;
  logic reset;
  pc_sequencer_if #(.PC_W(PC_W)) bus ();

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(9'd0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Behavioural model: waiting-for-instruction flag, halted flag, PC and link as plain integers
  int m_pc;
  int m_link;
  bit m_waiting;
  bit m_halted;
  bit m_lwe;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_pc = 0; m_link = 0; m_waiting = 1'b1; m_halted = 1'b0; m_lwe = 1'b0;
    end else begin
      m_lwe = 1'b0;
      if (m_halted) begin
        m_halted = 1'b1;
      end else if (m_waiting) begin
        if (bus.imem_ready) m_waiting = 1'b0;
      end else if (bus.stall) begin
        m_waiting = 1'b0;
      end else if (bus.halt) begin
        m_halted = 1'b1;
      end else begin
        if (bus.ctrl_en && bus.is_jal) begin
          m_link = (m_pc + 1) % MOD;
          m_lwe  = 1'b1;
        end
        if (!bus.ctrl_en)  m_pc = (m_pc + 1) % MOD;
        else if (bus.jump) m_pc = int'(bus.endout);
        else               m_pc = (int'(bus.endout) + 1) % MOD;
        m_waiting = 1'b1;
      end
    end
  endtask

  // Compare process: DUT outputs against the model, away from the rising edge
  always @(negedge clock) begin
    if (check_en) begin
      chk("pc", int'(bus.pc), m_pc);
      chk("fetch_req", int'(bus.fetch_req), int'(m_waiting && !m_halted));
      chk("halted", int'(bus.halted), int'(m_halted));
      chk("link_addr", int'(bus.link_addr), m_link);
      chk("link_we", int'(bus.link_we), int'(m_lwe));
    end
  end

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic set_in(input bit ce, input bit j, input int eo, input bit jal,
                        input bit st, input bit h, input bit rdy);
    bus.ctrl_en    = ce;
    bus.jump       = j;
    bus.endout     = PC_W'(eo);
    bus.is_jal     = jal;
    bus.stall      = st;
    bus.halt       = h;
    bus.imem_ready = rdy;
  endtask

  task automatic fetch_ok();
    set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
  endtask

  task automatic exec(input bit ce, input bit j, input int eo, input bit jal,
                      input bit st, input bit h);
    set_in(ce, j, eo, jal, st, h, 1'b1);
    cycle();
  endtask

  task automatic goto_pc(input int target);
    fetch_ok();
    exec(1'b1, 1'b1, target, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    reset = 1'b0;
    check_en = 1'b1;
    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_fetch_req", int'(bus.fetch_req), 1);
    chk("rst_halted", int'(bus.halted), 0);
    chk("rst_link_we", int'(bus.link_we), 0);

    // Sequential stepping: pc 0,0,1,1,2 with fetch_req alternating
    cycle(); chk("seq_pc0", int'(bus.pc), 0); chk("seq_fr0", int'(bus.fetch_req), 0);
    cycle(); chk("seq_pc1", int'(bus.pc), 1); chk("seq_fr1", int'(bus.fetch_req), 1);
    cycle(); chk("seq_pc1b", int'(bus.pc), 1);
    cycle(); chk("seq_pc2", int'(bus.pc), 2);

    // Branch taken and not taken
    goto_pc(5);
    fetch_ok(); exec(1'b1, 1'b0, 12, 1'b0, 1'b0, 1'b0);
    chk("br_taken", int'(bus.pc), 13);
    goto_pc(5);
    fetch_ok(); exec(1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0);
    chk("br_not_taken", int'(bus.pc), 6);

    // jal
    goto_pc(20);
    fetch_ok(); exec(1'b1, 1'b1, 100, 1'b1, 1'b0, 1'b0);
    chk("jal_pc", int'(bus.pc), 100);
    chk("jal_link", int'(bus.link_addr), 21);
    chk("jal_we", int'(bus.link_we), 1);
    fetch_ok();
    chk("jal_we_drop", int'(bus.link_we), 0);
    chk("jal_link_hold", int'(bus.link_addr), 21);

    // Wrap at the top of the address space
    exec(1'b1, 1'b1, 511, 1'b0, 1'b0, 1'b0);
    fetch_ok(); exec(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("wrap_seq", int'(bus.pc), 0);
    goto_pc(511);
    fetch_ok(); exec(1'b1, 1'b0, 511, 1'b0, 1'b0, 1'b0);
    chk("wrap_branch", int'(bus.pc), 0);

    // Stall overrides halt, then halt freezes the core
    goto_pc(40);
    fetch_ok();
    for (int i = 0; i < 3; i++) begin
      exec(1'b1, 1'b1, 77, 1'b0, 1'b1, 1'b1);
      chk("stall_pc", int'(bus.pc), 40);
      chk("stall_halted", int'(bus.halted), 0);
    end
    exec(1'b1, 1'b1, 77, 1'b0, 1'b0, 1'b1);
    chk("halt_flag", int'(bus.halted), 1);
    chk("halt_pc", int'(bus.pc), 40);
    fetch_ok(); exec(1'b1, 1'b1, 300, 1'b1, 1'b0, 1'b0);
    chk("halt_frozen", int'(bus.pc), 40);
    chk("halt_no_fetch", int'(bus.fetch_req), 0);

    // Fetch starvation then reset
    reset = 1'b1; cycle(); reset = 1'b0;
    fetch_ok(); exec(1'b1, 1'b1, 200, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      chk("starve_pc", int'(bus.pc), 200);
      chk("starve_fr", int'(bus.fetch_req), 1);
    end
    reset = 1'b1; cycle(); reset = 1'b0;
    chk("rst2_pc", int'(bus.pc), 0);
    chk("rst2_link_we", int'(bus.link_we), 0);
    chk("rst2_link", int'(bus.link_addr), 0);
    fetch_ok();
    chk("rst2_in_exec", int'(bus.fetch_req), 0);

    // Reset during EXEC discards that cycle's PC update
    reset = 1'b1;
    exec(1'b1, 1'b1, 77, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    chk("rst_exec_pc", int'(bus.pc), 0);
    chk("rst_exec_fr", int'(bus.fetch_req), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      set_in($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             int'($urandom_range(0, MOD - 1)), $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 3) != 0);
      cycle();
    end
    reset = 1'b0;

    @(posedge clock); #1;
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
